niosqsys_input_pio_edge: RTL

- Parametrised Avalon-MM input PIO for the Nios Qsys system.
- Samples up to 32 asynchronous input lines through a configurable synchroniser.
- Exposes the synchronised data, a per-bit edge-capture register and a per-bit interrupt mask.
- Drives a level interrupt to the CPU; replaces fixed-width, read-only input ports such as the control-word port.

---
 rtl/niosqsys_input_pio_edge_if.sv | 11 +
 rtl/niosqsys_input_pio_edge.sv | 58 +++++
 2 files changed

// File: rtl/niosqsys_input_pio_edge_if.sv
// niosqsys_input_pio_edge_if: Avalon-MM slave bus bundle for the input PIO.
interface niosqsys_input_pio_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/niosqsys_input_pio_edge.sv
// niosqsys_input_pio_edge: synchronised input PIO with edge capture, irq mask and level irq.
module niosqsys_input_pio_edge #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int IRQ_ENABLE  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    niosqsys_input_pio_edge_if.slave  bus,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);
    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int CW       = $clog2(WARM_MAX + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in, prev, edge_capture, irq_mask, det, clr;
    logic [CW-1:0]    warm;
    logic             warm_done, wr;
    logic [31:0]      rd_mux;

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign warm_done = warm == CW'(WARM_MAX);
    assign wr        = bus.chipselect & ~bus.write_n;

    // edges stay masked until the chain and prev hold real samples
    always_comb begin
        det    = !warm_done     ? '0 :
                 EDGE_MODE == 0 ? sync_in & ~prev :
                 EDGE_MODE == 1 ? ~sync_in & prev : sync_in ^ prev;
        clr    = wr && bus.address == 2'd3 ? bus.writedata[WIDTH-1:0] : '0;
        rd_mux = bus.address == 2'd0 ? 32'(sync_in) :
                 bus.address == 2'd2 ? 32'(irq_mask) :
                 bus.address == 2'd3 ? 32'(edge_capture) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev         <= '0;
            warm         <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev         <= sync_in;
            warm         <= warm_done ? warm : warm + 1'b1;
            edge_capture <= det | (edge_capture & ~clr);
            if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
            bus.readdata <= rd_mux;
            irq          <= IRQ_ENABLE != 0 && |(edge_capture & irq_mask);
        end
    end
endmodule
